// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: datapath widths, the $zero register
// number and the write-back control bundle.
package mips_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic RegWrite;
        logic MemToReg;
    } wb_ctrl_t;

endpackage

// File: rtl/mem_wb_reg_pipe_reg.sv
// Generic pipeline register: captures d on every rising edge, clears to 0 on
// asynchronous active-low reset.
module pipe_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_q <= '0;
        else        r_q <= d;
    end

    assign q = r_q;

endmodule

// File: rtl/mem_wb_reg.sv
// MEM->WB pipeline register; a data-memory miss becomes a write-back bubble.
// Define WB_MUX_EN to add the registered write-back mux output writeData.
module mem_wb_reg
    import mips_pkg::*;
#(
    parameter int DATA_W     = mips_pkg::DATA_W,
    parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hit,
    input  logic [DATA_W-1:0]     readData,
    input  logic [DATA_W-1:0]     ALUResult,
    input  logic [REG_ADDR_W-1:0] writeReg,
    input  logic                  RegWrite,
    input  logic                  MemToReg,
    output logic                  hitOut,
    output logic [DATA_W-1:0]     readDataOut,
    output logic [DATA_W-1:0]     ALUResultOut,
    output logic [REG_ADDR_W-1:0] writeRegOut,
    output logic                  RegWriteOut,
    output logic                  MemToRegOut
`ifdef WB_MUX_EN
    ,
    output logic [DATA_W-1:0]     writeData
`endif
);

    localparam int BUS_W = 1 + 2*DATA_W + REG_ADDR_W;

    logic [BUS_W-1:0] w_data_d;
    logic [BUS_W-1:0] w_data_q;
    wb_ctrl_t         w_ctrl_d;
    wb_ctrl_t         w_ctrl_q;

    assign w_data_d = {hit, readData, ALUResult, writeReg};

    pipe_reg #(.W(BUS_W)) u_data (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (w_data_d),
        .q     (w_data_q)
    );

    // Miss bubbles both flags; a write to $zero is never allowed to reach the RF.
    always_comb begin
        w_ctrl_d.RegWrite = RegWrite;
        w_ctrl_d.MemToReg = MemToReg;
        if (writeReg == REG_ADDR_W'(REG_ZERO))
            w_ctrl_d.RegWrite = 1'b0;
        if (!hit) begin
            w_ctrl_d.RegWrite = 1'b0;
            w_ctrl_d.MemToReg = 1'b0;
        end
    end

    pipe_reg #(.W($bits(wb_ctrl_t))) u_ctrl (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (w_ctrl_d),
        .q     (w_ctrl_q)
    );

    assign {hitOut, readDataOut, ALUResultOut, writeRegOut} = w_data_q;
    assign RegWriteOut = w_ctrl_q.RegWrite;
    assign MemToRegOut = w_ctrl_q.MemToReg;

`ifdef WB_MUX_EN
    // Registers clear on reset, so writeData is 0 during reset as well.
    assign writeData = MemToRegOut ? readDataOut : ALUResultOut;
`endif

endmodule

// File: tb/tb_mem_wb_reg.sv
// Directed + randomized bench for mem_wb_reg against a behavioural expectation model.
module tb_mem_wb_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hit;
    logic [31:0] readData, ALUResult;
    logic [4:0]  writeReg;
    logic        RegWrite, MemToReg;
    logic        hitOut, RegWriteOut, MemToRegOut;
    logic [31:0] readDataOut, ALUResultOut;
    logic [4:0]  writeRegOut;
`ifdef WB_MUX_EN
    logic [31:0] writeData;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        hit;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic        rw;
        logic        m2r;
    } exp_t;

    exp_t q_exp[$];

    mem_wb_reg dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hit          (hit),
        .readData     (readData),
        .ALUResult    (ALUResult),
        .writeReg     (writeReg),
        .RegWrite     (RegWrite),
        .MemToReg     (MemToReg),
        .hitOut       (hitOut),
        .readDataOut  (readDataOut),
        .ALUResultOut (ALUResultOut),
        .writeRegOut  (writeRegOut),
        .RegWriteOut  (RegWriteOut),
        .MemToRegOut  (MemToRegOut)
`ifdef WB_MUX_EN
        ,
        .writeData    (writeData)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // What the WB stage should see for a given set of MEM-stage inputs.
    function automatic exp_t model(input logic h, input logic [31:0] rd, input logic [31:0] alu,
                                   input logic [4:0] wr, input logic rw, input logic m2r);
        exp_t e;
        e.hit = h;
        e.rd  = rd;
        e.alu = alu;
        e.wr  = wr;
        e.rw  = h && rw && (wr != 5'd0);
        e.m2r = h && m2r;
        return e;
    endfunction

    function automatic exp_t zero_exp();
        return model(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    endfunction

    task automatic check_all(input string tag, input exp_t e);
        chk({tag, ".hit"}, 32'(hitOut), 32'(e.hit));
        chk({tag, ".rd"},  readDataOut, e.rd);
        chk({tag, ".alu"}, ALUResultOut, e.alu);
        chk({tag, ".wr"},  32'(writeRegOut), 32'(e.wr));
        chk({tag, ".rw"},  32'(RegWriteOut), 32'(e.rw));
        chk({tag, ".m2r"}, 32'(MemToRegOut), 32'(e.m2r));
`ifdef WB_MUX_EN
        chk({tag, ".wd"},  writeData, e.m2r ? e.rd : e.alu);
`endif
    endtask

    task automatic drive(input logic h, input logic [31:0] rd, input logic [31:0] alu,
                         input logic [4:0] wr, input logic rw, input logic m2r);
        hit = h; readData = rd; ALUResult = alu; writeReg = wr; RegWrite = rw; MemToReg = m2r;
    endtask

    task automatic drive_rand();
        drive($urandom_range(0, 3) != 0, $urandom, $urandom,
              ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
              1'($urandom), 1'($urandom));
    endtask

    function automatic exp_t model_now();
        return model(hit, readData, ALUResult, writeReg, RegWrite, MemToReg);
    endfunction

    initial begin
        // Reset held with random inputs and the clock running.
        drive_rand();
        #1 check_all("rst_init", zero_exp());
        for (int i = 0; i < 3; i++) begin
            @(negedge clk) drive_rand();
            @(posedge clk) #1 check_all("rst_hold", zero_exp());
        end

        // Capture with hit.
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 32'hDEADBEEF, 32'h00000010, 5'd8, 1'b1, 1'b1);
        @(posedge clk) #1 check_all("hit", model(1'b1, 32'hDEADBEEF, 32'h10, 5'd8, 1'b1, 1'b1));
`ifdef WB_MUX_EN
        chk("hit.wd_const", writeData, 32'hDEADBEEF);
`endif

        // Miss bubbles the flags, data still captured.
        @(negedge clk) hit = 1'b0;
        @(posedge clk) #1 check_all("miss", model(1'b0, 32'hDEADBEEF, 32'h10, 5'd8, 1'b1, 1'b1));
        chk("miss.rw_const", 32'(RegWriteOut), 32'd0);

        // Write to $zero is suppressed, MemToReg passes through.
        @(negedge clk) drive(1'b1, 32'hCAFEF00D, 32'h5, 5'd0, 1'b1, 1'b0);
        @(posedge clk) #1 check_all("zero", model(1'b1, 32'hCAFEF00D, 32'h5, 5'd0, 1'b1, 1'b0));
        chk("zero.alu_const", ALUResultOut, 32'h5);

        // Miss and $zero together.
        @(negedge clk) drive(1'b0, 32'h1234, 32'h5678, 5'd0, 1'b1, 1'b1);
        @(posedge clk) #1 check_all("miss_zero", model(1'b0, 32'h1234, 32'h5678, 5'd0, 1'b1, 1'b1));

        // MemToReg alone on a hit to $zero.
        @(negedge clk) drive(1'b1, 32'hA5A5A5A5, 32'h3C3C3C3C, 5'd0, 1'b0, 1'b1);
        @(posedge clk) #1 check_all("zero_m2r", model(1'b1, 32'hA5A5A5A5, 32'h3C3C3C3C, 5'd0, 1'b0, 1'b1));

        // Mid-cycle reset assertion: outputs clear without an edge.
        @(negedge clk) drive(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31, 1'b1, 1'b1);
        @(posedge clk) #1 check_all("pre_rst", model(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31, 1'b1, 1'b1));
        #2 rst_n = 1'b0;
        #1 check_all("async_rst", zero_exp());

        // First edge after release captures normally.
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 32'h11112222, 32'h33334444, 5'd17, 1'b1, 1'b0);
        @(posedge clk) #1 check_all("post_rst", model(1'b1, 32'h11112222, 32'h33334444, 5'd17, 1'b1, 1'b0));

        // Back-to-back random beats, expected values flow through a queue.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            drive_rand();
            q_exp.push_back(model_now());
            @(posedge clk) #1;
            if (q_exp.size() == 0) begin
                total++;
                bad++;
                $error("FAIL b2b: observed=empty_queue expected=entry");
            end else begin
                check_all($sformatf("b2b%0d", i), q_exp.pop_front());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
